bus_fabric: RTL and testbench

//  Parametrised single-master to N_SLV-slave data-bus fabric; successor to the fixed-decode SoC bus.

---
 rtl/bus_fabric_if.sv | 22 ++
 rtl/bus_fabric.sv | 127 ++++++++++++
 tb/tb_bus_fabric.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// Master-side data bus of the fabric: OBI-style request/grant plus a registered response.
interface bus_fabric_if;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_err;

   modport master (
      output data_req, data_we, data_be, data_addr, data_wdata,
      input  data_gnt, data_rvalid, data_rdata, data_err
   );

   modport slave (
      input  data_req, data_we, data_be, data_addr, data_wdata,
      output data_gnt, data_rvalid, data_rdata, data_err
   );
endinterface

// File: rtl/bus_fabric.sv
// Single-master to N_SLV-slave data-bus fabric with one outstanding transaction,
// wait-state pass-through, unmapped/timeout error responses and error logging.
module bus_fabric #(
   parameter int unsigned N_SLV    = 8,
   parameter int unsigned SEL_LSB  = 13,
   parameter int unsigned SEL_W    = 4,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   bus_fabric_if.slave           data,
   output logic [N_SLV-1:0]      s_req_o,
   output logic                  s_we_o,
   output logic [3:0]            s_be_o,
   output logic [31:0]           s_addr_o,
   output logic [31:0]           s_wdata_o,
   input  logic [N_SLV-1:0]      s_gnt_i,
   input  logic [N_SLV-1:0]      s_rvalid_i,
   input  logic [32*N_SLV-1:0]   s_rdata_i,
   output logic [31:0]           err_addr_o,
   output logic [7:0]            err_cnt_o,
   output logic                  err_irq_o
);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [SEL_W-1:0]  sel;
   logic [SEL_W-1:0]  cur;
   logic [31:0]       addr_q;
   logic [TW-1:0]     timer;
   logic              mapped;
   logic              gnt_sel;
   logic              rvalid_cur;
   logic [31:0]       rdata_cur;
   logic              handshake;
   logic              timer_exp;

   assign sel    = data.data_addr[SEL_LSB +: SEL_W];
   assign mapped = (32'(sel) < N_SLV);

   assign s_we_o    = data.data_we;
   assign s_be_o    = data.data_be;
   assign s_addr_o  = data.data_addr;
   assign s_wdata_o = data.data_wdata;

   // Slave selection by loop keeps indexing in range when sel is unmapped.
   always_comb begin
      s_req_o    = '0;
      gnt_sel    = 1'b0;
      rvalid_cur = 1'b0;
      rdata_cur  = '0;
      for (int unsigned k = 0; k < N_SLV; k++) begin
         if (sel == SEL_W'(k)) begin
            s_req_o[k] = (state == IDLE) && data.data_req;
            gnt_sel    = s_gnt_i[k];
         end
         if (cur == SEL_W'(k)) begin
            rvalid_cur = s_rvalid_i[k];
            rdata_cur  = s_rdata_i[32*k +: 32];
         end
      end
   end

   assign data.data_gnt = (state == IDLE) && (mapped ? gnt_sel : data.data_req);
   assign handshake     = data.data_req && data.data_gnt;
   assign timer_exp     = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         cur              <= '0;
         addr_q           <= '0;
         timer            <= '0;
         data.data_rvalid <= 1'b0;
         data.data_rdata  <= '0;
         data.data_err    <= 1'b0;
         err_addr_o       <= '0;
         err_cnt_o        <= '0;
         err_irq_o        <= 1'b0;
      end else begin
         data.data_rvalid <= 1'b0;
         err_irq_o        <= 1'b0;
         case (state)
            IDLE: begin
               if (handshake) begin
                  if (mapped) begin
                     cur    <= sel;
                     addr_q <= data.data_addr;
                     timer  <= '0;
                     state  <= BUSY;
                  end else begin
                     data.data_rvalid <= 1'b1;
                     data.data_err    <= 1'b1;
                     data.data_rdata  <= ERR_DATA;
                     err_addr_o       <= data.data_addr;
                     err_irq_o        <= 1'b1;
                     if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                  end
               end
            end
            BUSY: begin
               // Slave response takes priority over a timeout expiring in the same cycle.
               if (rvalid_cur) begin
                  data.data_rvalid <= 1'b1;
                  data.data_err    <= 1'b0;
                  data.data_rdata  <= rdata_cur;
                  state            <= IDLE;
               end else if (timer_exp) begin
                  data.data_rvalid <= 1'b1;
                  data.data_err    <= 1'b1;
                  data.data_rdata  <= ERR_DATA;
                  err_addr_o       <= addr_q;
                  err_irq_o        <= 1'b1;
                  if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                  state            <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: wait states, unmapped and timeout errors, back-to-back, reset.
module tb_bus_fabric;
   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     s_req;
   logic           s_we;
   logic [3:0]     s_be;
   logic [31:0]    s_addr;
   logic [31:0]    s_wdata;
   logic [7:0]     s_gnt;
   logic [7:0]     s_rvalid;
   logic [255:0]   s_rdata;
   logic [31:0]    err_addr;
   logic [7:0]     err_cnt;
   logic           err_irq;

   int unsigned errors = 0;
   int unsigned checks = 0;

   bus_fabric_if bus ();

   bus_fabric #(.N_SLV(8), .SEL_LSB(13), .SEL_W(4), .TIMEOUT(255), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .data       (bus.slave),
      .s_req_o    (s_req),
      .s_we_o     (s_we),
      .s_be_o     (s_be),
      .s_addr_o   (s_addr),
      .s_wdata_o  (s_wdata),
      .s_gnt_i    (s_gnt),
      .s_rvalid_i (s_rvalid),
      .s_rdata_i  (s_rdata),
      .err_addr_o (err_addr),
      .err_cnt_o  (err_cnt),
      .err_irq_o  (err_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int unsigned n;
      int unsigned stray;

      rst              = 1'b1;
      bus.data_req     = 1'b0;
      bus.data_we      = 1'b0;
      bus.data_be      = 4'hF;
      bus.data_addr    = '0;
      bus.data_wdata   = 32'hCAFE_0000;
      s_gnt            = '0;
      s_rvalid         = '0;
      s_rdata          = '0;
      tick();
      settle();
      check("rst_rvalid", 32'(bus.data_rvalid), 32'd0);
      check("rst_rdata", bus.data_rdata, 32'd0);
      check("rst_err", 32'(bus.data_err), 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_irq", 32'(err_irq), 32'd0);
      check("rst_s_req", 32'(s_req), 32'd0);
      check("rst_gnt", 32'(bus.data_gnt), 32'd0);
      rst = 1'b0;
      tick();

      // 1: read slave 2 with 3 wait states, response 2 cycles after grant
      bus.data_req  = 1'b1;
      bus.data_we   = 1'b0;
      bus.data_addr = 32'h0000_4000;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("t1_wait_s_req", 32'(s_req), 32'h04);
         check("t1_wait_gnt", 32'(bus.data_gnt), 32'd0);
         tick();
      end
      s_gnt = 8'h04;
      settle();
      check("t1_grant_s_req", 32'(s_req), 32'h04);
      check("t1_grant_gnt", 32'(bus.data_gnt), 32'd1);
      check("t1_bcast_addr", s_addr, 32'h0000_4000);
      tick();
      settle();
      check("t1_busy_s_req", 32'(s_req), 32'd0);
      check("t1_busy_gnt", 32'(bus.data_gnt), 32'd0);
      check("t1_busy_rvalid", 32'(bus.data_rvalid), 32'd0);
      tick();
      bus.data_req = 1'b0;
      s_gnt        = '0;
      s_rvalid     = 8'h04;
      s_rdata[64 +: 32] = 32'h1234_5678;
      settle();
      check("t1_pre_rvalid", 32'(bus.data_rvalid), 32'd0);
      tick();
      s_rvalid = '0;
      settle();
      check("t1_rvalid", 32'(bus.data_rvalid), 32'd1);
      check("t1_rdata", bus.data_rdata, 32'h1234_5678);
      check("t1_err", 32'(bus.data_err), 32'd0);
      tick();
      settle();
      check("t1_rvalid_pulse", 32'(bus.data_rvalid), 32'd0);
      check("t1_rdata_held", bus.data_rdata, 32'h1234_5678);

      // 2: write to unmapped region (sel 9)
      bus.data_req  = 1'b1;
      bus.data_we   = 1'b1;
      bus.data_addr = 32'h0001_2000;
      settle();
      check("t2_gnt", 32'(bus.data_gnt), 32'd1);
      check("t2_s_req", 32'(s_req), 32'd0);
      tick();
      bus.data_req = 1'b0;
      bus.data_we  = 1'b0;
      settle();
      check("t2_rvalid", 32'(bus.data_rvalid), 32'd1);
      check("t2_err", 32'(bus.data_err), 32'd1);
      check("t2_rdata", bus.data_rdata, 32'hDEAD_BEEF);
      check("t2_err_addr", err_addr, 32'h0001_2000);
      check("t2_err_cnt", 32'(err_cnt), 32'd1);
      check("t2_irq", 32'(err_irq), 32'd1);
      tick();
      settle();
      check("t2_irq_pulse", 32'(err_irq), 32'd0);
      check("t2_rvalid_pulse", 32'(bus.data_rvalid), 32'd0);

      // 3: slave 0 grants but never responds
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h0000_0100;
      s_gnt         = 8'h01;
      tick();
      bus.data_req = 1'b0;
      s_gnt        = '0;
      n = 1;
      while (n < 300 && !bus.data_rvalid) begin
         tick();
         n++;
      end
      settle();
      check("t3_timeout_cycles", n - 1, 32'd255);
      check("t3_err", 32'(bus.data_err), 32'd1);
      check("t3_rdata", bus.data_rdata, 32'hDEAD_BEEF);
      check("t3_err_addr", err_addr, 32'h0000_0100);
      check("t3_err_cnt", 32'(err_cnt), 32'd2);
      check("t3_irq", 32'(err_irq), 32'd1);
      tick();
      s_rvalid = 8'h01;
      s_rdata[0 +: 32] = 32'h0BAD_0BAD;
      tick();
      s_rvalid = '0;
      settle();
      check("t3_late_rvalid", 32'(bus.data_rvalid), 32'd0);

      // 4: slave 1 responds exactly when the timer expires
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h0000_2000;
      s_gnt         = 8'h02;
      tick();
      bus.data_req = 1'b0;
      s_gnt        = '0;
      stray = 0;
      for (int i = 1; i < 255; i++) begin
         if (bus.data_rvalid) stray++;
         tick();
      end
      if (bus.data_rvalid) stray++;
      check("t4_no_early_resp", stray, 32'd0);
      s_rvalid = 8'h02;
      s_rdata[32 +: 32] = 32'hA5A5_0001;
      tick();
      s_rvalid = '0;
      settle();
      check("t4_rvalid", 32'(bus.data_rvalid), 32'd1);
      check("t4_err", 32'(bus.data_err), 32'd0);
      check("t4_rdata", bus.data_rdata, 32'hA5A5_0001);
      check("t4_err_cnt", 32'(err_cnt), 32'd2);
      check("t4_irq", 32'(err_irq), 32'd0);
      tick();

      // 5: back-to-back reads, slave 1 then slave 3, zero-wait slaves
      s_gnt         = 8'hFF;
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h0000_2000;
      settle();
      check("t5_a_s_req", 32'(s_req), 32'h02);
      check("t5_a_gnt", 32'(bus.data_gnt), 32'd1);
      tick();
      bus.data_addr = 32'h0000_6000;
      s_rvalid = 8'h02;
      s_rdata[32 +: 32] = 32'h1111_1111;
      settle();
      check("t5_busy_gnt", 32'(bus.data_gnt), 32'd0);
      tick();
      s_rvalid = '0;
      settle();
      check("t5_a_rvalid", 32'(bus.data_rvalid), 32'd1);
      check("t5_a_rdata", bus.data_rdata, 32'h1111_1111);
      check("t5_b_gnt", 32'(bus.data_gnt), 32'd1);
      check("t5_b_s_req", 32'(s_req), 32'h08);
      tick();
      bus.data_req = 1'b0;
      s_rvalid = 8'h0A;
      s_rdata[96 +: 32] = 32'h3333_3333;
      settle();
      check("t5_b_pre_rvalid", 32'(bus.data_rvalid), 32'd0);
      tick();
      s_rvalid = '0;
      settle();
      check("t5_b_rvalid", 32'(bus.data_rvalid), 32'd1);
      check("t5_b_rdata", bus.data_rdata, 32'h3333_3333);
      check("t5_b_err", 32'(bus.data_err), 32'd0);
      s_gnt = '0;
      tick();

      // 6: 300 unmapped accesses saturate the error counter
      bus.data_req  = 1'b1;
      bus.data_addr = 32'hFFFF_E000;
      for (int i = 0; i < 300; i++) tick();
      bus.data_req = 1'b0;
      settle();
      check("t6_err_cnt_sat", 32'(err_cnt), 32'd255);
      check("t6_err_addr", err_addr, 32'hFFFF_E000);
      tick();

      // reset while BUSY on slave 4
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h0000_8000;
      s_gnt         = 8'h10;
      tick();
      bus.data_req = 1'b0;
      s_gnt        = '0;
      s_rvalid     = 8'h10;
      s_rdata[128 +: 32] = 32'h4444_4444;
      rst          = 1'b1;
      settle();
      check("t6_rst_rvalid", 32'(bus.data_rvalid), 32'd0);
      check("t6_rst_rdata", bus.data_rdata, 32'd0);
      check("t6_rst_err", 32'(bus.data_err), 32'd0);
      check("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
      check("t6_rst_err_addr", err_addr, 32'd0);
      check("t6_rst_irq", 32'(err_irq), 32'd0);
      tick();
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.data_rvalid) stray++;
      end
      check("t6_no_stray_rvalid", stray, 32'd0);
      s_rvalid      = '0;
      bus.data_req  = 1'b1;
      settle();
      check("t6_idle_after_rst", 32'(s_req), 32'h10);
      bus.data_req = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
